// File: rtl/dm_resp.sv
// Single-port data-memory responder: accepts one load/store, waits LATENCY cycles,
// then holds a registered response until the initiator takes it.
module dm_resp #(
  parameter int DEPTH_WORDS = 3072,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready;
  // a response transfers on a rising edge with resp_valid && resp_ready.
  // trace_* pulses for one cycle after each committed store; the bench prints it.

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;
  logic        r_trace_valid;
  logic [31:0] r_trace_data;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_idx_ok;
  logic          w_be_legal;
  logic [3:0]    w_low_mask;
  logic          w_below;
  logic          w_err;
  logic [IW-1:0] w_idx;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;

  // Access decode runs purely on the captured request, never on live req_* pins.
  always_comb begin
    w_idx_ok   = ({2'b00, r_addr[31:2]} < 32'(DEPTH_WORDS));
    w_idx      = r_addr[IW+1:2];
    w_low_mask = (4'b0001 << r_addr[1:0]) - 4'b0001;
    w_below    = |(r_be & w_low_mask);
    case (r_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: w_be_legal = 1'b1;
      default:                   w_be_legal = 1'b0;
    endcase
    w_err  = !w_idx_ok || !w_be_legal || w_below;
    w_old  = w_idx_ok ? r_mem[w_idx] : 32'h0;
    w_merged = w_old;
    for (int i = 0; i < 4; i++) begin
      if (r_be[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 4'd0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_rdata  <= 32'h0;
      r_we          <= 1'b0;
      r_addr        <= 32'h0;
      r_be          <= 4'h0;
      r_wdata       <= 32'h0;
      r_pc          <= 32'h0;
      r_trace_valid <= 1'b0;
      r_trace_data  <= 32'h0;
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'h0;
    end else begin
      r_trace_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_be        <= req_be;
            r_wdata     <= req_wdata;
            r_pc        <= req_pc;
            r_cnt       <= 4'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_resp_rdata <= 32'h0;
            if (!w_err) begin
              if (r_we) begin
                r_mem[w_idx]  <= w_merged;
                r_trace_valid <= 1'b1;
                r_trace_data  <= w_merged;
              end else begin
                r_resp_rdata <= w_old;
              end
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_rdata  = r_resp_rdata;
  assign dbg_state   = r_state;
  assign trace_valid = r_trace_valid;
  assign trace_pc    = r_pc;
  assign trace_addr  = {r_addr[31:2], 2'b00};
  assign trace_data  = r_trace_data;

endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 3072, meaning number of 32-bit words of backing storage.
REQ-002 Parameter LATENCY, default 2, meaning cycles from request acceptance to response valid (legal range 1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_be  input  4  byte enables; bit i selects byte lane i (bits 8i+7:8i).
REQ-010 req_wdata  input  32  store data, lane-aligned.
REQ-011 req_pc  input  32  PC of the issuing instruction, for the write trace only.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  initiator accepts the response.
REQ-014 resp_rdata  output  32  full word at the addressed word, for loads; 0 for stores and errors.
REQ-015 resp_err  output  1  request was rejected (see REQ-024).

Function
REQ-016 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-017 In IDLE, req_ready SHALL be 1 and resp_valid 0; in BUSY and RESP, req_ready SHALL be 0.
REQ-018 A request SHALL be accepted when req_valid and req_ready are both 1 at a rising edge; req_we, req_addr, req_be, req_wdata and req_pc SHALL be captured on that edge and later input changes ignored.
REQ-019 On acceptance the FSM SHALL go IDLE->BUSY and load a 4-bit countdown with LATENCY-1.
REQ-020 In BUSY the countdown SHALL decrement each cycle; the edge at which it reads 0 SHALL perform the access and move to RESP, so resp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-021 In RESP, resp_valid SHALL stay 1 with resp_rdata and resp_err stable until resp_ready is 1 at a rising edge, then SHALL move to IDLE (no back-to-back acceptance on the same edge).
REQ-022 Word index SHALL be req_addr[31:2]; byte offset SHALL be req_addr[1:0].
REQ-023 A store SHALL update only the enabled lanes of the indexed word; disabled lanes SHALL keep their old value.
REQ-024 resp_err SHALL be 1, with no storage change and resp_rdata 0, when any of these holds:
- word index >= DEPTH_WORDS
- req_be is 0000
- req_be is not one of 0001, 0010, 0100, 1000, 0011, 1100 or 1111
- an enabled lane lies below the byte offset (e.g. be=0011 with offset 2)
REQ-025 A load without error SHALL return the whole stored word; lane extraction and sign extension are the initiator's job.
REQ-026 Each successful store SHALL emit one simulation trace line "@<pc hex>: *<word-aligned addr hex> <= <merged word hex>".
REQ-027 Storage SHALL be modelled as a register array read and written only by the FSM; there SHALL be no combinational path from req_* to resp_*.

Reset
REQ-028 While reset is 0: FSM = IDLE, countdown = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, req_ready = 1, and every storage word = 0.
REQ-029 Reset asserted during BUSY or RESP SHALL abort the transaction: no store commits, no response is produced, and the first request after reset release is accepted normally.

Verification
REQ-030 Store then load: LATENCY=2; store addr 0x10, be=1111, wdata 0xDEADBEEF, pc 0x3000; then load 0x10 -> resp_valid 2 cycles after each acceptance, load resp_rdata 0xDEADBEEF, trace "@00003000: *00000010 <= deadbeef".
REQ-031 Partial store: word 0x20 holds 0x11223344; store be=0100, wdata 0x00AA0000 -> reload gives 0x11AA3344.
REQ-032 Backpressure: resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0; the new req_valid is not accepted until the cycle after resp_ready=1.
REQ-033 Errors: store to word index DEPTH_WORDS; store with be=0101; store with be=0011 at addr offset 2 -> resp_err 1 and resp_rdata 0 each time, no trace line, target words unchanged.
REQ-034 Reset mid-operation: assert reset in the BUSY cycle of a store to 0x40 -> after release resp_valid 0, req_ready 1, and a load of 0x40 returns 0.
REQ-035 Latency sweep: LATENCY=1 and LATENCY=15 -> resp_valid rises exactly 1 and 15 cycles after acceptance.
